// File: rtl/sequence_bit_serializer.sv
// Parallel-to-serial feeder for the "1011" sequence detector: valid/ready word input,
// one shift register plus one hold register so back-to-back words stream without a gap.
module sequence_bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_n;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] hold_n;
  logic             hold_full;
  logic             hold_full_n;
  logic [BCW-1:0]   bit_cnt;
  logic [BCW-1:0]   bit_cnt_n;
  logic [CNT_W-1:0] sent_q;
  logic [CNT_W-1:0] sent_n;
  logic             seq_q;
  logic             seq_n;
  logic             bit_valid_q;
  logic             bit_valid_n;
  logic             word_done_q;
  logic             word_done_n;
  logic             busy_q;
  logic             busy_n;
  logic             accept;
  logic             last_bit;

  // The bit on the line is always the head of the shift register in the chosen order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign data_ready = reset && !hold_full;
  assign accept     = data_valid && data_ready;
  assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_IDX);

  always_comb begin
    state_n     = state;
    shift_n     = shift_reg;
    hold_n      = hold_reg;
    hold_full_n = hold_full;
    bit_cnt_n   = bit_cnt;
    sent_n      = sent_q;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_n   = data_in;
          bit_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // End of word: the next word (hold first, else a same-edge accept) starts with no gap.
          sent_n    = sent_q + CNT_W'(1);
          bit_cnt_n = '0;
          if (hold_full) begin
            shift_n     = hold_reg;
            hold_full_n = 1'b0;
          end else if (accept) begin
            shift_n = data_in;
          end else begin
            shift_n = advance(shift_reg);
            state_n = IDLE;
          end
        end else begin
          shift_n   = advance(shift_reg);
          bit_cnt_n = bit_cnt + BCW'(1);
          if (accept) begin
            hold_n      = data_in;
            hold_full_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered from next-state values so they line up with the shifted bit.
    seq_n       = (state_n == SHIFT) ? head_bit(shift_n) : IDLE_BIT;
    bit_valid_n = (state_n == SHIFT);
    word_done_n = (state_n == SHIFT) && (bit_cnt_n == LAST_IDX);
    busy_n      = (state_n == SHIFT) || hold_full_n;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      sent_q      <= '0;
      seq_q       <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      shift_reg   <= shift_n;
      hold_reg    <= hold_n;
      hold_full   <= hold_full_n;
      bit_cnt     <= bit_cnt_n;
      sent_q      <= sent_n;
      seq_q       <= seq_n;
      bit_valid_q <= bit_valid_n;
      word_done_q <= word_done_n;
      busy_q      <= busy_n;
    end
  end

  assign sequence_out = seq_q;
  assign bit_valid    = bit_valid_q;
  assign word_done    = word_done_q;
  assign busy         = busy_q;
  assign words_sent   = sent_q;

endmodule

// File: tb/tb_sequence_bit_serializer.sv
// Bench for sequence_bit_serializer: two instances (MSB-first/16-bit count, LSB-first/2-bit count)
// checked every cycle against a bit-queue model of the serial stream.
module tb_sequence_bit_serializer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [7:0]  a_data;
  logic        a_valid;
  logic        a_ready, a_seq, a_bv, a_wd, a_busy;
  logic [15:0] a_sent;

  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_ready, b_seq, b_bv, b_wd, b_busy;
  logic [1:0]  b_sent;

  sequence_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .data_in(a_data), .data_valid(a_valid),
    .data_ready(a_ready), .sequence_out(a_seq), .bit_valid(a_bv), .word_done(a_wd),
    .busy(a_busy), .words_sent(a_sent)
  );

  sequence_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .data_in(b_data), .data_valid(b_valid),
    .data_ready(b_ready), .sequence_out(b_seq), .bit_valid(b_bv), .word_done(b_wd),
    .busy(b_busy), .words_sent(b_sent)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: every accepted word is expanded into its bits in line order; the line shows the
  // queue head each cycle, and a second word is "in hold" whenever more than 8 bits remain.
  bit          qa[$];
  bit          la[$];
  bit          qb[$];
  bit          lb[$];
  logic [15:0] ma_sent;
  logic [1:0]  mb_sent;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qa.delete(); la.delete(); qb.delete(); lb.delete();
    ma_sent = '0;
    mb_sent = '0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step(output bit acc_a, output bit acc_b);
    bit hv;
    @(negedge clock);
    hv = qa.size() > 0;
    check_bit("a_seq", a_seq, hv ? qa[0] : 1'b0);
    check_bit("a_bit_valid", a_bv, hv);
    check_bit("a_word_done", a_wd, hv && la[0]);
    check_bit("a_busy", a_busy, hv);
    check_bit("a_ready", a_ready, qa.size() <= 8);
    check_word("a_words_sent", a_sent, ma_sent);
    acc_a = a_valid && (qa.size() <= 8);
    hv = qb.size() > 0;
    check_bit("b_seq", b_seq, hv ? qb[0] : 1'b0);
    check_bit("b_bit_valid", b_bv, hv);
    check_bit("b_word_done", b_wd, hv && lb[0]);
    check_bit("b_busy", b_busy, hv);
    check_bit("b_ready", b_ready, qb.size() <= 8);
    check_word("b_words_sent", {14'b0, b_sent}, {14'b0, mb_sent});
    acc_b = b_valid && (qb.size() <= 8);
    @(posedge clock);
    if (qa.size() > 0) begin
      if (la[0]) ma_sent = ma_sent + 16'd1;
      void'(qa.pop_front()); void'(la.pop_front());
    end
    if (qb.size() > 0) begin
      if (lb[0]) mb_sent = mb_sent + 2'd1;
      void'(qb.pop_front()); void'(lb.pop_front());
    end
    if (acc_a) for (int i = 0; i < 8; i++) begin qa.push_back(a_data[7-i]); la.push_back(i == 7); end
    if (acc_b) for (int i = 0; i < 8; i++) begin qb.push_back(b_data[i]); lb.push_back(i == 7); end
    #1;
  endtask

  task automatic idle_steps(input int n);
    bit x, y;
    for (int i = 0; i < n; i++) step(x, y);
  endtask

  task automatic send_a(input logic [7:0] w);
    bit acc, y;
    int guard;
    a_data  = w;
    a_valid = 1'b1;
    guard   = 0;
    acc     = 1'b0;
    while (!acc && guard < 40) begin
      step(acc, y);
      guard++;
    end
    compared++;
    if (!acc) begin
      mismatched++;
      $display("[TB] FAIL send_a_timeout observed=no_accept expected=accept within 40 cycles");
    end
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] w);
    bit x, acc;
    int guard;
    b_data  = w;
    b_valid = 1'b1;
    guard   = 0;
    acc     = 1'b0;
    while (!acc && guard < 40) begin
      step(x, acc);
      guard++;
    end
    compared++;
    if (!acc) begin
      mismatched++;
      $display("[TB] FAIL send_b_timeout observed=no_accept expected=accept within 40 cycles");
    end
    b_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc_a, acc_b;
    reset   = 1'b0;
    a_data  = '0;
    a_valid = 1'b0;
    b_data  = '0;
    b_valid = 1'b0;
    model_clear();

    // Reset values while reset is held low.
    #23;
    check_bit("rst_seq", a_seq, 1'b0);
    check_bit("rst_bit_valid", a_bv, 1'b0);
    check_bit("rst_ready", a_ready, 1'b0);
    check_bit("rst_busy", a_busy, 1'b0);
    check_word("rst_words_sent", a_sent, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] idle for 20 cycles");
    idle_steps(20);

    $display("[TB] single word 8'hB5");
    send_a(8'hB5);
    idle_steps(10);

    $display("[TB] back-to-back 8'hB5, 8'h0B");
    send_a(8'hB5);
    send_a(8'h0B);
    idle_steps(20);

    $display("[TB] accept on the end-of-word edge");
    send_a(8'h3C);
    idle_steps(7);
    send_a(8'hD2);
    idle_steps(10);

    $display("[TB] reset during the 3rd bit of 8'hFF");
    model_clear();
    reset = 1'b0;
    #7;
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_a(8'hFF);
    idle_steps(2);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_bit("midrst_seq", a_seq, 1'b0);
    check_bit("midrst_bit_valid", a_bv, 1'b0);
    check_bit("midrst_ready", a_ready, 1'b0);
    check_bit("midrst_busy", a_busy, 1'b0);
    model_clear();
    #12;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_bit("postrst_ready", a_ready, 1'b1);
    check_word("postrst_words_sent", a_sent, 16'd0);
    @(posedge clock);
    #1;
    idle_steps(3);

    $display("[TB] LSB-first 8'hA5 x5 with a 2-bit counter");
    for (int i = 0; i < 5; i++) send_b(8'hA5);
    idle_steps(20);

    $display("[TB] randomized traffic on both instances");
    acc_a = 1'b1;
    acc_b = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(a_valid && !acc_a)) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = 8'($urandom);
      end
      if (!(b_valid && !acc_b)) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data  = 8'($urandom);
      end
      step(acc_a, acc_b);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    idle_steps(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sequence_bit_serializer.md
# sequence_bit_serializer

Upstream feeder for the "1011" Moore sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single serial line that drives the detector's serial input. Two words of buffering let back-to-back words stream with no idle gap. When there is nothing to send, the line is held at a fixed idle level so the detector always sees a defined bit.

## Interface
- WIDTH, 8, word width in bits; minimum 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on sequence_out when no word is being shifted.
- CNT_W, 16, width of the words_sent counter.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  in  WIDTH  parallel word to serialize.
- data_valid  in  1  data_in holds a word.
- data_ready  out  1  block can accept a word this cycle.
- sequence_out  out  1  serial bit, registered; connects to the detector's serial input.
- bit_valid  out  1  sequence_out carries a data bit, not the idle fill.
- word_done  out  1  high for the cycle in which the last bit of a word is on sequence_out.
- busy  out  1  shift register or hold register is occupied.
- words_sent  out  CNT_W  count of fully shifted words; wraps modulo 2^CNT_W.

## Operation
- Storage:
  - shift register plus bit counter (0..WIDTH-1);
  - one-word hold register with a hold_full flag.
- State machine:
  - IDLE: shift register empty.
  - SHIFT: a word is being output.
- Handshake:
  - A word is accepted at a rising edge when data_valid && data_ready.
  - data_ready = reset && !hold_full. It is combinational, 0 while reset is asserted, and independent of data_valid.
  - data_in is held stable by the producer only while data_valid && !data_ready.
- IDLE state:
  - sequence_out = IDLE_BIT, bit_valid = 0, word_done = 0.
  - On accept, the word loads directly into the shift register and the state moves to SHIFT. The hold register stays empty.
- SHIFT state:
  - sequence_out presents one bit per cycle in the MSB_FIRST order, with bit_valid = 1.
  - The bit counter increments each cycle.
  - An accept while hold is empty writes the word to the hold register and sets hold_full.
- End of word (the edge that ends the cycle showing the last bit, counter = WIDTH-1):
  - words_sent increments.
  - If hold_full: the hold word moves into the shift register, hold_full clears, and the state stays SHIFT.
  - Else if an accept occurs at that same edge: data_in loads directly into the shift register and the state stays SHIFT.
  - Else: the state moves to IDLE.
  - In every case a following word starts in the very next cycle with no gap.
- Accept and hold-to-shift transfer at the same edge: impossible, because ready = 0 while hold is full.
- busy = (state == SHIFT) || hold_full.
- words_sent wraps from 2^CNT_W-1 to 0 without a flag.

## Timing
- Reset values (during reset and immediately after it deasserts):
  - sequence_out = IDLE_BIT; bit_valid, word_done, busy = 0; words_sent = 0.
  - State IDLE, hold empty, data_ready = 0 while reset is low.
- Latency: a word accepted at edge N shows its first bit on sequence_out from edge N to N+1. The detector samples it at edge N+1.
- A word occupies exactly WIDTH consecutive cycles. Sustained throughput is one word per WIDTH cycles.
- word_done is asserted in the same cycle as the last bit. words_sent reflects the increment after that cycle's closing edge.
- Reset mid-word is asynchronous: the partial word and the hold word are discarded, and sequence_out returns to IDLE_BIT immediately. No partial-word count is recorded.
- All outputs except data_ready are registered.

## Test plan
- Reset then idle, data_valid = 0 for 20 cycles -> sequence_out = 0, bit_valid = 0, busy = 0, data_ready = 1, words_sent = 0.
- Single word 8'hB5, MSB_FIRST = 1 -> serial 1,0,1,1,0,1,0,1 over the 8 cycles after the accept edge. word_done is high only on the 8th bit. words_sent = 1. A detector attached to sequence_out asserts its output one cycle after the 4th bit.
- Back-to-back 8'hB5, 8'h0B with data_valid held high -> the second word is accepted into hold during the first word. data_ready drops for the remainder of the first word. 16 contiguous bits arrive with bit_valid never low between words. words_sent = 2.
- Accept exactly at the end-of-word edge with hold empty -> the new word's first bit follows the previous word's last bit with no idle cycle.
- Assert reset low on the 3rd bit of 8'hFF -> sequence_out = 0 and bit_valid = 0 immediately. After release, data_ready = 1 and words_sent is unchanged at its pre-word value, i.e. 0 when starting from reset.
- CNT_W = 2, send 5 words of 8'hA5 with MSB_FIRST = 0 -> each word is sent LSB-first as 1,0,1,0,0,1,0,1. words_sent reads 1,2,3,0,1.
